// File: rtl/weight_preloader_pkg.sv
// rtl/weight_preloader_pkg.sv - shared state encoding and address widths for the weight preloader
package weight_preloader_pkg;

  localparam int ROW_W_DEF = 7;
  localparam int COL_W_DEF = 7;
  localparam int ADDR_W    = ROW_W_DEF + COL_W_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FIRE,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/weight_preloader_if.sv
// rtl/weight_preloader_if.sv - weight stream in and mesh preload port out
interface weight_preloader_if #(
  parameter int DW = 8,
  parameter int AW = weight_preloader_pkg::ADDR_W
);

  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] s_data;
  logic                 preload_valid;
  logic [AW-1:0]        preload_addr;
  logic signed [DW-1:0] preload_data;

  modport master (
    output s_valid, s_data,
    input  s_ready, preload_valid, preload_addr, preload_data
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, preload_valid, preload_addr, preload_data
  );

endinterface

// File: rtl/weight_preloader_rc_counter.sv
// rtl/weight_preloader_rc_counter.sv - row-major row/column index counter with wrap
module rc_counter #(
  parameter int ROWS  = 40,
  parameter int COLS  = 40,
  parameter int ROW_W = 7,
  parameter int COL_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (inc) begin
      if (col_q == COL_W'(COLS - 1)) begin
        col_d = '0;
        // Wrapping the row too keeps indices in range after the final beat.
        row_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == ROW_W'(ROWS - 1)) && (col_q == COL_W'(COLS - 1));

endmodule

// File: rtl/weight_preloader.sv
// rtl/weight_preloader.sv - streams a row-major weight matrix into a mesh, then kicks and drains it
module weight_preloader
  import weight_preloader_pkg::*;
#(
  parameter int DW        = 8,
  parameter int ROWS      = 40,
  parameter int COLS      = 40,
  parameter int ROW_W     = ROW_W_DEF,
  parameter int COL_W     = COL_W_DEF,
  parameter int DRAIN_CYC = ROWS + COLS + 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  input  logic [COLS*DW-1:0]   x_in,
  weight_preloader_if.slave    s_if,
  output logic                 start,
  output logic [COLS*DW-1:0]   x_vector_flat,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYC - 1);

  state_e                     state_q, state_d;
  logic                       pv_q, pv_d;
  logic [ROW_W+COL_W-1:0]     pa_q, pa_d;
  logic signed [DW-1:0]       pd_q, pd_d;
  logic                       start_q, start_d;
  logic                       done_q, done_d;
  logic [COLS*DW-1:0]         x_q, x_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       rc_clr, rc_inc, rc_last;
  logic [ROW_W-1:0]           row;
  logic [COL_W-1:0]           col;
  logic                       accept;

  rc_counter #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_rc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (rc_clr),
    .inc   (rc_inc),
    .row   (row),
    .col   (col),
    .last  (rc_last)
  );

  assign accept = (state_q == ST_LOAD) && s_if.s_valid;

  always_comb begin
    state_d = state_q;
    pv_d    = 1'b0;
    pa_d    = pa_q;
    pd_d    = pd_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    x_d     = x_q;
    cnt_d   = cnt_q;
    rc_clr  = 1'b0;
    rc_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          x_d     = x_in;
          rc_clr  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          pv_d   = 1'b1;
          pa_d   = {row, col};
          pd_d   = s_if.s_data;
          rc_inc = 1'b1;
          if (rc_last) state_d = ST_FIRE;
        end
      end
      ST_FIRE: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The start cycle is drain cycle 0, so DONE lands DRAIN_CYC cycles after start.
        if (cnt_q == CNT_LAST) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pv_q    <= 1'b0;
      pa_q    <= '0;
      pd_q    <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pv_q    <= pv_d;
      pa_q    <= pa_d;
      pd_q    <= pd_d;
      start_q <= start_d;
      done_q  <= done_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s_if.s_ready       = (state_q == ST_LOAD);
  assign s_if.preload_valid = pv_q;
  assign s_if.preload_addr  = pa_q;
  assign s_if.preload_data  = pd_q;
  assign start              = start_q;
  assign done               = done_q;
  assign busy               = (state_q != ST_IDLE);
  assign x_vector_flat      = x_q;

endmodule

// File: tb/tb_weight_preloader.sv
// tb/tb_weight_preloader.sv - self-checking bench for weight_preloader on a 4x4 mesh
module tb_weight_preloader;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DC = 13;
  localparam int AW = 14;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            go    = 1'b0;
  logic [C*DW-1:0] x_in  = '0;
  logic [C*DW-1:0] exp_x = '0;
  logic [C*DW-1:0] x_vector_flat;
  logic            start, busy, done;

  weight_preloader_if #(.DW(DW), .AW(AW)) s_if ();

  weight_preloader #(
    .DW(DW), .ROWS(R), .COLS(C), .ROW_W(7), .COL_W(7), .DRAIN_CYC(DC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .go            (go),
    .x_in          (x_in),
    .s_if          (s_if.slave),
    .start         (start),
    .x_vector_flat (x_vector_flat),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } beat_t;

  beat_t         obs[$];
  logic [DW-1:0] sent[$];
  int cyc = 0, start_cnt = 0, done_cnt = 0, start_cyc = 0, done_cyc = 0, xbad = 0;
  int ncmp = 0, nfail = 0;

  always @(negedge clk) begin
    cyc++;
    if (s_if.preload_valid === 1'b1)
      obs.push_back('{s_if.preload_addr, s_if.preload_data, cyc});
    if (start === 1'b1) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy === 1'b1 && x_vector_flat !== exp_x) xbad++;
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    ncmp++;
    assert (observed === expected)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 64'({s_if.preload_valid, s_if.preload_addr, s_if.preload_data,
                    start, done, busy, s_if.s_ready, x_vector_flat}), 64'd0);
  endtask

  task automatic run_job(input bit dir_data, input int stall_at, input int stall_len,
                         input bit rand_stall, input bit noise, input int abort_at,
                         input logic [C*DW-1:0] xv);
    int  s0, d0, n, last;
    bit  r;
    logic [AW-1:0] ea;
    @(posedge clk); #1;
    obs.delete();
    sent.delete();
    s0 = start_cnt;
    d0 = done_cnt;
    xbad = 0;
    go = 1'b1;
    x_in = xv;
    exp_x = xv;
    @(posedge clk); #1;
    go = 1'b0;
    x_in = $urandom;
    for (int k = 0; k < R*C; k++) begin
      s_if.s_valid = 1'b1;
      s_if.s_data  = dir_data ? DW'(k / C + k % C) : DW'($urandom);
      sent.push_back(s_if.s_data);
      if (noise && k == 3) begin
        go = 1'b1;
        x_in = $urandom;
      end
      n = 0;
      do begin
        @(negedge clk);
        r = s_if.s_ready;
        @(posedge clk); #1;
        go = 1'b0;
        n++;
      end while (!r && n < 50);
      s_if.s_valid = 1'b0;
      if (!r) begin
        check("accept_timeout", 64'(r), 64'd1);
        return;
      end
      if (k == abort_at) begin
        check("busy_mid_job", 64'(busy), 64'd1);
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset_async_zero");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        s0 = start_cnt;
        d0 = done_cnt;
        repeat (40) @(posedge clk);
        #1;
        check("no_start_after_reset", 64'(start_cnt - s0), 64'd0);
        check("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
        check("idle_after_reset", 64'(busy), 64'd0);
        return;
      end
      if (k == stall_at) begin
        repeat (stall_len) begin @(posedge clk); #1; end
      end else if (rand_stall && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
    end
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (noise && n == 5) begin
        go = 1'b1;
        x_in = $urandom;
      end else begin
        go = 1'b0;
      end
    end
    check("done_seen", 64'(done), 64'd1);
    if (noise) begin
      go = 1'b1;
      x_in = $urandom;
      @(posedge clk); #1;
      go = 1'b0;
      check("go_in_done_ignored_busy", 64'(busy), 64'd0);
      check("go_in_done_ignored_ready", 64'(s_if.s_ready), 64'd0);
    end
    @(negedge clk); #1;
    check("beat_count", 64'(obs.size()), 64'(R*C));
    for (int k = 0; k < R*C && k < obs.size(); k++) begin
      ea = {7'(k / C), 7'(k % C)};
      check($sformatf("addr[%0d]", k), 64'(obs[k].addr), 64'(ea));
      check($sformatf("data[%0d]", k), 64'(obs[k].data), 64'(sent[k]));
    end
    if (obs.size() == R*C) begin
      last = obs[R*C-1].cyc;
      if (stall_at >= 0)
        check("stall_gap", 64'(obs[stall_at+1].cyc - obs[stall_at].cyc), 64'(stall_len + 1));
      if (!rand_stall && stall_at < 0)
        check("back_to_back", 64'(last - obs[0].cyc), 64'(R*C - 1));
      check("start_after_last_beat", 64'(start_cyc), 64'(last + 1));
    end
    check("one_start", 64'(start_cnt - s0), 64'd1);
    check("one_done", 64'(done_cnt - d0), 64'd1);
    check("done_latency", 64'(done_cyc - start_cyc), 64'(DC));
    check("xvec_stable_cycles_bad", 64'(xbad), 64'd0);
    check("xvec_hold", 64'(x_vector_flat), 64'(exp_x));
  endtask

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset_state");
    rst_n = 1'b1;
    run_job(1'b1, -1, 0, 1'b0, 1'b0, -1, {8'd4, 8'd3, 8'd2, 8'd1});
    run_job(1'b0, 5, 3, 1'b0, 1'b1, -1, C*DW'($urandom));
    run_job(1'b0, -1, 0, 1'b1, 1'b0, -1, C*DW'($urandom));
    run_job(1'b0, -1, 0, 1'b0, 1'b0, 9, C*DW'($urandom));
    run_job(1'b1, -1, 0, 1'b0, 1'b0, -1, C*DW'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
